// File: rtl/button_gesture.sv
// Turns a debounced button level into one-cycle gesture pulses.
// The pulses are short, long, double and auto-repeat, and busy is high outside IDLE.
module button_gesture #(
    parameter bit PRESSED_LEVEL     = 1'b0,
    parameter int LONG_CYCLES       = 50000000,
    parameter int DOUBLE_GAP_CYCLES = 12500000,
    parameter int REPEAT_CYCLES     = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       repeat_press,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int MAX_A = (LONG_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int MAX_C = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LIM  = CW'(DOUBLE_GAP_CYCLES - 1);
    localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [2:0] {
        S_RELEASE = 3'd0,
        S_IDLE    = 3'd1,
        S_PRESS1  = 3'd2,
        S_GAP     = 3'd3,
        S_LONG    = 3'd4
    } state_t;

    // Power-up values match the reset values.
    state_t        state        = S_RELEASE;
    logic [CW-1:0] cnt          = '0;
    logic          short_q      = 1'b0;
    logic          long_q       = 1'b0;
    logic          double_q     = 1'b0;
    logic          repeat_q     = 1'b0;
    logic          busy_q       = 1'b1;

    state_t        state_n;
    logic [CW-1:0] cnt_n;
    logic          short_n, long_n, double_n, repeat_n;
    logic          p;

    assign p = (in == PRESSED_LEVEL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_RELEASE;
            cnt      <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            short_q  <= short_n;
            long_q   <= long_n;
            double_q <= double_n;
            repeat_q <= repeat_n;
            busy_q   <= (state_n != S_IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        short_n  = 1'b0;
        long_n   = 1'b0;
        double_n = 1'b0;
        repeat_n = 1'b0;
        case (state)
            S_RELEASE: begin
                if (!p) state_n = S_IDLE;
            end
            S_IDLE: begin
                if (p) begin
                    state_n = S_PRESS1;
                    cnt_n   = ONE;
                end
            end
            S_PRESS1: begin
                if (p) begin
                    if (cnt == LONG_LIM) begin
                        state_n = S_LONG;
                        long_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end else if (DOUBLE_GAP_CYCLES == 0) begin
                    state_n = S_IDLE;
                    short_n = 1'b1;
                end else begin
                    state_n = S_GAP;
                    cnt_n   = ONE;
                end
            end
            S_GAP: begin
                // The second press is swallowed until the button is let go.
                if (p) begin
                    state_n  = S_RELEASE;
                    double_n = 1'b1;
                end else if (cnt == GAP_LIM) begin
                    state_n = S_IDLE;
                    short_n = 1'b1;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            S_LONG: begin
                if (!p) begin
                    state_n = S_IDLE;
                end else if (REPEAT_CYCLES != 0) begin
                    if (cnt == REP_LIM) begin
                        repeat_n = 1'b1;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
            end
            default: state_n = S_RELEASE;
        endcase
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign repeat_press = repeat_q;
    assign busy         = busy_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture: a table of per-cycle vectors with queued expectations,
// plus a hand-driven sequence on a second instance with double detection disabled.
module tb_button_gesture;

    logic       clk = 1'b0;
    logic       rst_n, in, in0;
    logic       short_press, long_press, double_press, repeat_press, busy;
    logic [2:0] dbg_state;
    logic       short0, long0, double0, repeat0, busy0;
    logic [2:0] dbg_state0;

    always #5 clk = ~clk;

    button_gesture #(
        .PRESSED_LEVEL(1'b0), .LONG_CYCLES(8), .DOUBLE_GAP_CYCLES(4), .REPEAT_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in),
        .short_press(short_press), .long_press(long_press), .double_press(double_press),
        .repeat_press(repeat_press), .busy(busy), .dbg_state(dbg_state)
    );

    button_gesture #(
        .PRESSED_LEVEL(1'b0), .LONG_CYCLES(8), .DOUBLE_GAP_CYCLES(0), .REPEAT_CYCLES(3)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .in(in0),
        .short_press(short0), .long_press(long0), .double_press(double0),
        .repeat_press(repeat0), .busy(busy0), .dbg_state(dbg_state0)
    );

    // Expected word layout: {short, long, double, repeat, busy}
    typedef struct {
        int         sc;
        logic       rst_n;
        logic       in;
        logic [4:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] exp_q[$];
    logic [4:0] exp0_q[$];
    int         total = 0;
    int         bad   = 0;

    function automatic string sc_name(input int sc);
        case (sc)
            0:       return "short_press";
            1:       return "long_repeat";
            2:       return "double_press";
            3:       return "held_thru_reset";
            4:       return "reset_mid_gesture";
            default: return "dg0_short";
        endcase
    endfunction

    function automatic void add(input int sc, input int n, input logic r, input logic i,
                                input logic [4:0] e);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.sc = sc; v.rst_n = r; v.in = i; v.exp = e;
            vecs.push_back(v);
        end
    endfunction

    task automatic drive(input vec_t v, input int idx);
        logic [4:0] got, e;
        @(negedge clk);
        rst_n = v.rst_n;
        in    = v.in;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        got = {short_press, long_press, double_press, repeat_press, busy};
        e   = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s step %0d got=%b expected=%b", sc_name(v.sc), idx, got, e);
        end
    endtask

    task automatic drive0(input logic i, input int idx);
        logic [4:0] got, e;
        @(negedge clk);
        in0 = i;
        @(posedge clk);
        #1;
        got = {short0, long0, double0, repeat0, busy0};
        e   = exp0_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s step %0d got=%b expected=%b", sc_name(5), idx, got, e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in    = 1'b1;
        in0   = 1'b1;

        // Short press: reset idle-high, press 3, release 6.
        add(0, 2, 1'b0, 1'b1, 5'b00001);
        add(0, 2, 1'b1, 1'b1, 5'b00000);
        add(0, 3, 1'b1, 1'b0, 5'b00001);
        add(0, 3, 1'b1, 1'b1, 5'b00001);
        add(0, 1, 1'b1, 1'b1, 5'b10000);
        add(0, 2, 1'b1, 1'b1, 5'b00000);
        // Long press with repeat: hold 15, then release.
        add(1, 7, 1'b1, 1'b0, 5'b00001);
        add(1, 1, 1'b1, 1'b0, 5'b01001);
        add(1, 2, 1'b1, 1'b0, 5'b00001);
        add(1, 1, 1'b1, 1'b0, 5'b00011);
        add(1, 2, 1'b1, 1'b0, 5'b00001);
        add(1, 1, 1'b1, 1'b0, 5'b00011);
        add(1, 1, 1'b1, 1'b0, 5'b00001);
        add(1, 2, 1'b1, 1'b1, 5'b00000);
        // Double press: press 3, release 2, press 2, release.
        add(2, 3, 1'b1, 1'b0, 5'b00001);
        add(2, 2, 1'b1, 1'b1, 5'b00001);
        add(2, 1, 1'b1, 1'b0, 5'b00101);
        add(2, 1, 1'b1, 1'b0, 5'b00001);
        add(2, 6, 1'b1, 1'b1, 5'b00000);
        // Held through reset, then a normal short press.
        add(3, 3, 1'b0, 1'b0, 5'b00001);
        add(3, 20, 1'b1, 1'b0, 5'b00001);
        add(3, 1, 1'b1, 1'b1, 5'b00000);
        add(3, 3, 1'b1, 1'b0, 5'b00001);
        add(3, 3, 1'b1, 1'b1, 5'b00001);
        add(3, 1, 1'b1, 1'b1, 5'b10000);
        add(3, 1, 1'b1, 1'b1, 5'b00000);
        // Reset at pressed sample 5, button stays held past the long threshold.
        add(4, 4, 1'b1, 1'b0, 5'b00001);
        add(4, 1, 1'b0, 1'b0, 5'b00001);
        add(4, 12, 1'b1, 1'b0, 5'b00001);
        add(4, 3, 1'b1, 1'b1, 5'b00000);

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i], i);

        // Double detection disabled: short fires right after the first release.
        begin
            logic in_seq [8];
            logic [4:0] ex_seq [8];
            in_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            ex_seq = '{5'b00001, 5'b00001, 5'b00001, 5'b10000,
                       5'b00000, 5'b00001, 5'b10000, 5'b00000};
            for (int i = 0; i < 8; i++) begin
                exp0_q.push_back(ex_seq[i]);
                drive0(in_seq[i], i);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
